// File: rtl/mem_arbiter_2p.sv
// Two-port round-robin arbiter and access sequencer for a single-port synchronous memory,
// with a zero-fill clear sweep. Every output is driven straight from a register.
module mem_arbiter_2p #(
  parameter int unsigned ADDR_W = 8,
  parameter int unsigned DATA_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              a_req,
  input  logic              a_rw,
  input  logic [ADDR_W-1:0] a_addr,
  input  logic [DATA_W-1:0] a_wdata,
  output logic              a_ack,
  output logic [DATA_W-1:0] a_rdata,
  input  logic              b_req,
  input  logic              b_rw,
  input  logic [ADDR_W-1:0] b_addr,
  input  logic [DATA_W-1:0] b_wdata,
  output logic              b_ack,
  output logic [DATA_W-1:0] b_rdata,
  input  logic              clr_req,
  output logic              clr_done,
  output logic              busy,
  output logic              mem_r_w,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
);

  typedef enum logic [1:0] {StIdle, StIssue, StWait, StClear} state_e;

  state_e              state_q, state_d;
  logic                last_b_q, last_b_d;  // 1: port B received the most recent grant
  logic                sel_b_q, sel_b_d;    // port currently being served
  logic                rd_q, rd_d;          // current access is a read
  logic                r_w_q, r_w_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [DATA_W-1:0]   wdata_q, wdata_d;
  logic                a_ack_q, a_ack_d, b_ack_q, b_ack_d;
  logic [DATA_W-1:0]   a_rdata_q, a_rdata_d, b_rdata_q, b_rdata_d;
  logic                clr_done_q, clr_done_d;
  logic                busy_q, busy_d;
  logic                a_elig, b_elig, grant_b;

  // A port whose ack is high this cycle is still dropping req; do not re-grant it yet.
  assign a_elig = a_req & ~a_ack_q;
  assign b_elig = b_req & ~b_ack_q;

  always_comb begin
    state_d    = state_q;
    last_b_d   = last_b_q;
    sel_b_d    = sel_b_q;
    rd_d       = rd_q;
    r_w_d      = r_w_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    a_ack_d    = 1'b0;
    b_ack_d    = 1'b0;
    a_rdata_d  = a_rdata_q;
    b_rdata_d  = b_rdata_q;
    clr_done_d = 1'b0;
    grant_b    = b_elig & (~a_elig | ~last_b_q);

    unique case (state_q)
      StIdle: begin
        if (clr_req) begin
          state_d = StClear;
          r_w_d   = 1'b0;
          addr_d  = '0;
          wdata_d = '0;
        end else if (a_elig || b_elig) begin
          state_d  = StIssue;
          sel_b_d  = grant_b;
          last_b_d = grant_b;
          rd_d     = grant_b ? b_rw : a_rw;
          r_w_d    = grant_b ? b_rw : a_rw;
          addr_d   = grant_b ? b_addr : a_addr;
          wdata_d  = grant_b ? b_wdata : a_wdata;
        end
      end
      StIssue: begin
        r_w_d   = 1'b1;
        state_d = StWait;
      end
      StWait: begin
        state_d = StIdle;
        if (sel_b_q) begin
          b_ack_d = 1'b1;
          if (rd_q) b_rdata_d = mem_rdata;
        end else begin
          a_ack_d = 1'b1;
          if (rd_q) a_rdata_d = mem_rdata;
        end
      end
      StClear: begin
        if (addr_q == {ADDR_W{1'b1}}) begin
          state_d    = StIdle;
          r_w_d      = 1'b1;
          addr_d     = '0;
          clr_done_d = 1'b1;
        end else begin
          addr_d = addr_q + ADDR_W'(1);
        end
      end
      default: state_d = StIdle;
    endcase

    busy_d = (state_d != StIdle);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= StIdle;
      last_b_q   <= 1'b1;
      sel_b_q    <= 1'b0;
      rd_q       <= 1'b1;
      r_w_q      <= 1'b1;
      addr_q     <= '0;
      wdata_q    <= '0;
      a_ack_q    <= 1'b0;
      b_ack_q    <= 1'b0;
      a_rdata_q  <= '0;
      b_rdata_q  <= '0;
      clr_done_q <= 1'b0;
      busy_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      last_b_q   <= last_b_d;
      sel_b_q    <= sel_b_d;
      rd_q       <= rd_d;
      r_w_q      <= r_w_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      a_ack_q    <= a_ack_d;
      b_ack_q    <= b_ack_d;
      a_rdata_q  <= a_rdata_d;
      b_rdata_q  <= b_rdata_d;
      clr_done_q <= clr_done_d;
      busy_q     <= busy_d;
    end
  end

  assign a_ack     = a_ack_q;
  assign b_ack     = b_ack_q;
  assign a_rdata   = a_rdata_q;
  assign b_rdata   = b_rdata_q;
  assign clr_done  = clr_done_q;
  assign busy      = busy_q;
  assign mem_r_w   = r_w_q;
  assign mem_addr  = addr_q;
  assign mem_wdata = wdata_q;

endmodule

// File: doc/mem_arbiter_2p.md
Name: mem_arbiter_2p

Overview:
- Two-port arbiter/sequencer in front of the 256x8 single-port memory block.
- Shares the memory between port A (instruction fetch) and port B (data/load-store) with round-robin arbitration.
- Sequences each access into the memory's timing and drives all memory control pins.
- Provides a clear sequencer that writes zero to every location on request.

Parameters:
- ADDR_W, 8, memory address width; depth = 2**ADDR_W.
- DATA_W, 8, memory data width.

Ports:
- clk  in  1  system clock, all state on rising edge.
- rst  in  1  asynchronous, active-low reset.
- a_req  in  1  port A request; held high until a_ack.
- a_rw  in  1  port A direction; 1 = read, 0 = write.
- a_addr  in  ADDR_W  port A address.
- a_wdata  in  DATA_W  port A write data.
- a_ack  out  1  port A completion, one-cycle pulse.
- a_rdata  out  DATA_W  port A read data, valid while a_ack = 1.
- b_req, b_rw, b_addr, b_wdata, b_ack, b_rdata: same as port A, for port B.
- clr_req  in  1  start clear sweep; level, sampled in IDLE.
- clr_done  out  1  one-cycle pulse when the sweep completes.
- busy  out  1  high in any state other than IDLE.
- mem_r_w  out  1  memory direction; 1 = read, 0 = write.
- mem_addr  out  ADDR_W  memory address.
- mem_wdata  out  DATA_W  memory write data.
- mem_rdata  in  DATA_W  memory registered read output.

Behaviour:
- All outputs are registered.
- Reset (async, rst = 0):
  - state = IDLE; mem_r_w = 1; mem_addr = 0; mem_wdata = 0.
  - a_ack = b_ack = 0; a_rdata = b_rdata = 0; clr_done = 0; busy = 0.
  - last_grant = B, so port A wins the first contention.
- The memory writes on every edge where r_w = 0. mem_r_w must therefore be 1 in every state except the ISSUE cycle of a write and CLEAR.
- States: IDLE, ISSUE, WAIT, CLEAR.
- IDLE, at each edge, in priority order:
  - clr_req = 1: go to CLEAR; mem_r_w = 0, mem_addr = 0, mem_wdata = 0.
  - Otherwise, for eligible requests: if both are eligible, grant the port that is not last_grant; else grant the single eligible one.
  - On a grant: latch the port's rw/addr/wdata into mem_r_w/mem_addr/mem_wdata; update last_grant; go to ISSUE.
  - A port is eligible when its req = 1 and its ack is not currently high. This suppresses re-grant while the requester drops req.
- ISSUE (1 cycle): the memory performs the operation at this edge. Then set mem_r_w = 1 (addr unchanged) and go to WAIT.
- WAIT (1 cycle): mem_rdata is valid.
  - At the edge: granted port's rdata <= mem_rdata (reads only; unchanged for writes); granted port's ack <= 1; go to IDLE.
- ack deasserts the following cycle unconditionally.
- Latency: req sampled at edge E0; memory operates at E1; ack high in the cycle after E2. Throughput is one access per 3 cycles; back-to-back same-port accesses take 4 (ack-cycle suppression).
- Ungranted requests wait with req held; no starvation, since round-robin alternates under continuous contention.
- CLEAR: one write per cycle, mem_r_w = 0, mem_wdata = 0, mem_addr increments 0..2**ADDR_W-1.
  - At the edge where mem_addr = max: mem_r_w <= 1, mem_addr <= 0, clr_done <= 1, go to IDLE.
  - Duration: 256 cycles at default width.
  - Requests arriving during CLEAR wait. clr_req is ignored outside IDLE; if still high when back in IDLE, a new sweep starts.
- Simultaneous clr_req and a port request in IDLE: the clear wins; the request is served after clr_done.
- req dropped before ack (protocol violation): the access still completes and ack still pulses.
- Reset mid-operation: returns immediately to reset values. mem_r_w = 1 stops any in-progress write or clear; partial clear contents are left as-is.
- Address arithmetic is ADDR_W bits, unsigned; the clear counter stops at max and does not wrap.

Test Plan:
- Single read: after reset, preload mem[0x10] = 0x5A; pulse-hold a_req, a_rw = 1, a_addr = 0x10 -> mem_addr = 0x10 and mem_r_w = 1 in ISSUE; a_ack = 1 with a_rdata = 0x5A exactly 3 cycles after the sampling edge; b_ack stays 0.
- Write then read: b writes 0xC3 to 0xFF -> mem_r_w = 0 for exactly one cycle; b_ack pulses; b then reads 0xFF -> b_rdata = 0xC3.
- Contention: a_req and b_req high together continuously for 4 accesses -> grant order A, B, A, B; each port's ack pulses once per access; no double grant during the ack cycle.
- Idle safety: no requests for 20 cycles -> mem_r_w held at 1; memory contents unchanged.
- Clear: fill mem with 0xFF; assert clr_req together with a_req -> 256 consecutive cycles of mem_r_w = 0 with addresses 0..255; clr_done pulses; a is then served and reads 0x00 from any address.
- Reset mid-clear: drop rst at address 0x40 of the sweep -> all outputs at reset values immediately with mem_r_w = 1; addresses at or above 0x40 retain their old value.
